// File: rtl/e_result_streamer.sv
// e_result_streamer
//
// Turns the multi-word fixed-point result of the e-approximation datapath
// into a decimal ASCII stream: integer digit, '.', DIGITS fractional digits
// and '\n'. The output is a valid/ready byte interface.
//
// Ports:
//   clk        system clock, rising edge
//   rst        asynchronous, active-high reset
//   load       capture strobe (squaring block's done pulse)
//   in_data    WORDS x 16-bit value, word 0 = integer part, rest = fraction
//   out_char   ASCII character currently offered
//   out_valid  out_char is valid
//   out_ready  sink accepts out_char this cycle
//   out_last   high with the final '\n' of a stream
//   busy       stream in progress; load ignored while high
//   err        integer word exceeded 9 for the current/most recent stream
module e_result_streamer #(
  parameter int WORDS  = 32,
  parameter int DIGITS = 20
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    load,
  input  logic [0:WORDS-1][15:0]  in_data,
  output logic [7:0]              out_char,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    out_last,
  output logic                    busy,
  output logic                    err
);

  localparam int F  = 16 * (WORDS - 1);
  localparam int CW = $clog2(DIGITS + 1);

  typedef enum logic [2:0] {S_IDLE, S_INT, S_DOT, S_FRAC, S_NL} state_t;

  state_t          state_q, state_d;
  // Only the low nibble of the integer word is ever printed; values above 9
  // are flagged through err and printed as '#'.
  logic [3:0]      int_q, int_d;
  logic [F-1:0]    frac_q, frac_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            err_q, err_d;

  logic [16*WORDS-1:0] flat;
  logic [F+3:0]        frac_ext;
  logic [F+3:0]        prod;

  assign flat = in_data;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      int_q   <= '0;
      frac_q  <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      int_q   <= int_d;
      frac_q  <= frac_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    int_d     = int_q;
    frac_d    = frac_q;
    cnt_d     = cnt_q;
    err_d     = err_q;
    out_char  = 8'h00;
    out_valid = 1'b0;
    out_last  = 1'b0;
    busy      = 1'b0;
    // frac*10 as (frac<<3)+(frac<<1); the 4 carry-out bits are the next digit.
    frac_ext  = {4'b0000, frac_q};
    prod      = (frac_ext << 3) + (frac_ext << 1);

    case (state_q)
      S_IDLE: begin
        if (load) begin
          int_d   = flat[16*WORDS-16 +: 4];
          frac_d  = flat[F-1:0];
          cnt_d   = '0;
          err_d   = (flat[16*WORDS-1 -: 16] > 16'd9);
          state_d = S_INT;
        end
      end
      S_INT: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        out_char  = err_q ? 8'h23 : (8'h30 + {4'b0000, int_q});
        if (out_ready) state_d = S_DOT;
      end
      S_DOT: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        out_char  = 8'h2E;
        if (out_ready) state_d = S_FRAC;
      end
      S_FRAC: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        out_char  = 8'h30 + {4'b0000, prod[F+3:F]};
        if (out_ready) begin
          frac_d = prod[F-1:0];
          cnt_d  = cnt_q + 1'b1;
          if (cnt_q == CW'(DIGITS - 1)) state_d = S_NL;
        end
      end
      S_NL: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        out_last  = 1'b1;
        out_char  = 8'h0A;
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign err = err_q;

endmodule

// File: tb/tb_e_result_streamer.sv
// Testbench for e_result_streamer: directed and randomized streams checked
// against a decimal long-multiplication reference model.
module tb_e_result_streamer;

  localparam int WORDS  = 32;
  localparam int DIGITS = 20;

  logic                   clk = 1'b0;
  logic                   rst;
  logic                   load;
  logic [0:WORDS-1][15:0] in_data;
  logic [7:0]             out_char;
  logic                   out_valid;
  logic                   out_ready;
  logic                   out_last;
  logic                   busy;
  logic                   err;

  e_result_streamer #(.WORDS(WORDS), .DIGITS(DIGITS)) dut (
    .clk(clk), .rst(rst), .load(load), .in_data(in_data),
    .out_char(out_char), .out_valid(out_valid), .out_ready(out_ready),
    .out_last(out_last), .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  int          checks;
  int          failures;
  logic [15:0] words [WORDS];
  byte unsigned exp_q[$];
  logic        exp_err;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: print word0, then repeatedly multiply the fraction (as an
  // array of base-65536 limbs) by ten; the carry out of the top limb is the
  // next decimal digit.
  task automatic build_expected();
    int unsigned fr [WORDS];
    int unsigned carry, t;
    byte unsigned c;
    exp_q.delete();
    if (words[0] > 16'd9) c = 8'h23;
    else                  c = 8'h30 + words[0][7:0];
    exp_q.push_back(c);
    exp_q.push_back(8'h2E);
    for (int i = 1; i < WORDS; i++) fr[i] = words[i];
    for (int d = 0; d < DIGITS; d++) begin
      carry = 0;
      for (int i = WORDS - 1; i >= 1; i--) begin
        t     = fr[i] * 10 + carry;
        fr[i] = t % 65536;
        carry = t / 65536;
      end
      c = 8'h30 + carry[7:0];
      exp_q.push_back(c);
    end
    exp_q.push_back(8'h0A);
  endtask

  task automatic set_e();
    for (int i = 0; i < WORDS; i++) words[i] = 16'h0000;
    words[0] = 16'h0002;
    words[1] = 16'hB7E1; words[2] = 16'h5162; words[3] = 16'h8AED; words[4] = 16'h2A6A;
    words[5] = 16'hBF71; words[6] = 16'h5880; words[7] = 16'h9CF4; words[8] = 16'hF3C7;
  endtask

  task automatic set_two(input logic [15:0] w0, input logic [15:0] w1);
    for (int i = 0; i < WORDS; i++) words[i] = 16'h0000;
    words[0] = w0;
    words[1] = w1;
  endtask

  // Check idle outputs at a falling edge, then present a load for the next edge.
  task automatic start_stream();
    @(negedge clk);
    chk("idle_busy", busy, 1'b0);
    chk("idle_valid", out_valid, 1'b0);
    chk("idle_last", out_last, 1'b0);
    chk("idle_char", out_char, 8'h00);
    chk("idle_err", err, exp_err);
    for (int i = 0; i < WORDS; i++) in_data[i] = words[i];
    load      = 1'b1;
    out_ready = 1'b0;
    build_expected();
    exp_err = (words[0] > 16'd9);
  endtask

  // mode 0: ready always high; mode 1: ready pattern 1,0,0 repeating.
  // inject: raise load with other data on the 5th character and on '\n'.
  task automatic receive(input int mode, input bit inject, input int stop_at);
    int          idx = 0;
    int          cyc = 0;
    bit          stalled = 1'b0;
    logic [7:0]  held = 8'h00;
    logic        rdy;
    int          last;
    last = exp_q.size() - 1;
    while (idx < stop_at && cyc < 200) begin
      @(negedge clk);
      load = 1'b0;
      chk("valid", out_valid, 1'b1);
      chk("busy", busy, 1'b1);
      chk("err", err, exp_err);
      if (stalled) chk("stall_hold", out_char, held);
      chk("char", out_char, exp_q[idx]);
      chk("last", out_last, logic'(idx == last));
      rdy = (mode == 0) ? 1'b1 : logic'(cyc % 3 == 0);
      if (inject && (idx == 4 || idx == last)) begin
        load       = 1'b1;
        in_data[0] = 16'h0007;
        for (int i = 1; i < WORDS; i++) in_data[i] = 16'($urandom);
      end
      out_ready = rdy;
      if (rdy) idx++;
      stalled = !rdy;
      held    = out_char;
      cyc++;
    end
    chk("complete", idx, stop_at);
  endtask

  initial begin
    checks    = 0;
    failures  = 0;
    exp_err   = 1'b0;
    rst       = 1'b1;
    load      = 1'b0;
    out_ready = 1'b0;
    in_data   = '0;
    for (int i = 0; i < WORDS; i++) words[i] = 16'h0000;
    repeat (2) @(negedge clk);
    chk("rst_busy", busy, 1'b0);
    chk("rst_valid", out_valid, 1'b0);
    chk("rst_last", out_last, 1'b0);
    chk("rst_char", out_char, 8'h00);
    chk("rst_err", err, 1'b0);
    rst = 1'b0;

    // e constant, full rate
    set_e();
    start_stream();
    receive(0, 1'b0, DIGITS + 3);

    // exact half
    set_two(16'd1, 16'h8000);
    start_stream();
    receive(0, 1'b0, DIGITS + 3);

    // backpressure
    set_e();
    start_stream();
    receive(1, 1'b0, DIGITS + 3);

    // integer overflow; err stays set through idle until next load
    set_two(16'd12, 16'h4000);
    start_stream();
    receive(0, 1'b0, DIGITS + 3);

    // loads while busy are ignored; new stream right after busy falls
    set_e();
    start_stream();
    receive(0, 1'b1, DIGITS + 3);
    set_two(16'd3, 16'h2000);
    start_stream();
    receive(0, 1'b0, DIGITS + 3);

    // asynchronous reset during the 7th fractional digit
    set_two(16'd12, 16'h4000);
    start_stream();
    receive(0, 1'b0, 8);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("arst_valid", out_valid, 1'b0);
    chk("arst_busy", busy, 1'b0);
    chk("arst_last", out_last, 1'b0);
    chk("arst_err", err, 1'b0);
    chk("arst_char", out_char, 8'h00);
    out_ready = 1'b0;
    @(negedge clk);
    rst     = 1'b0;
    exp_err = 1'b0;
    set_e();
    start_stream();
    receive(0, 1'b0, DIGITS + 3);

    // randomized values and ready patterns
    for (int r = 0; r < 8; r++) begin
      for (int i = 0; i < WORDS; i++) words[i] = 16'($urandom);
      words[0] = 16'($urandom_range(0, 12));
      start_stream();
      receive(r % 2, 1'b0, DIGITS + 3);
    end

    @(negedge clk);
    load = 1'b0;
    chk("end_busy", busy, 1'b0);
    chk("end_valid", out_valid, 1'b0);
    chk("end_err", err, exp_err);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/e_result_streamer.md
# e_result_streamer

Converts the multi-word fixed-point result of the e-approximation datapath into a decimal ASCII character stream. The input is the WORDS×16-bit value that the repeated-squaring block delivers with its one-cycle `done` pulse. The block captures that value, then emits the integer digit, a '.', DIGITS fractional digits and a newline over a valid/ready byte interface. The byte interface feeds the board's UART/console path.

## Interface
- WORDS, 32, number of 16-bit words in the input value; word 0 is most significant.
- DIGITS, 20, number of fractional decimal digits emitted (1..63).
- clk  input  1  system clock; all state changes on rising edge.
- rst  input  1  reset, asynchronous, active-high. One clock; reset is asynchronous and active-high.
- load  input  1  capture strobe; connect to the squaring block's `done`.
- in_data  input  16×[0:WORDS-1]  value to print; word 0 = integer part, words 1..WORDS-1 = binary fraction (MSB first).
- out_char  output  8  ASCII character currently offered.
- out_valid  output  1  out_char is valid.
- out_ready  input  1  sink accepts out_char this cycle.
- out_last  output  1  high with the final character ('\n') of a stream.
- busy  output  1  stream in progress; load ignored while high.
- err  output  1  integer word was >9 for the current or most recent stream; sticky until next accepted load.

## Operation
- States: IDLE, INT, DOT, FRAC, NL.
- Reset values: state=IDLE, out_char=0x00, out_valid=0, out_last=0, busy=0, err=0, digit counter=0, fraction register=0, integer register=0.
- Handshake: a transfer occurs on any edge with out_valid&&out_ready. out_char and out_last hold stable while out_valid&&!out_ready.
- IDLE:
  - load=1 captures word 0 into the integer register and words 1..WORDS-1 into an F=16*(WORDS-1)-bit fraction register.
  - The same capture sets err=(word0>9), busy=1 and moves to INT.
- INT: offers '0'+word0 (0x30..0x39). If err is set, offers '#' (0x23) instead. Transfer → DOT.
- DOT: offers '.' (0x2E). Transfer → FRAC.
- FRAC:
  - Compute p = frac×10, width F+4, as (frac<<3)+(frac<<1).
  - Offer '0'+p[F+3:F].
  - On transfer: frac ← p[F-1:0], counter +1. When counter reaches DIGITS → NL.
- NL: offers 0x0A with out_last=1. Transfer → IDLE, busy=0, out_valid=0.
- load while busy=1 is ignored, including in the NL transfer cycle.
- in_data is sampled only at the accepted load edge; later changes do not affect the stream.
- Reset mid-stream: outputs return to reset values immediately. No partial character completes.

## Timing
- Accepted load at edge k: out_valid=1 and out_char=integer char are visible after edge k.
- With out_ready held high, one character transfers per cycle with no bubbles. The stream is DIGITS+3 characters, the last transferred at edge k+DIGITS+3.
- busy falls after the final transfer edge. The next load is accepted no earlier than the following edge.
- The ×10 step is combinational from the fraction register to out_char. The only registered update is on transfer.
- err is valid from the edge after the accepted load.

## Test plan
- e constant:
  - Stimulus: WORDS=32, word0=0x0002, words1..8=B7E1 5162 8AED 2A6A BF71 5880 9CF4 F3C7, rest 0, load pulse, out_ready=1.
  - Response: "2.71828182845904523536\n" in 23 consecutive cycles; out_last only on 0x0A; err=0.
- Exact half:
  - Stimulus: word0=1, word1=0x8000, rest 0.
  - Response: "1.50000000000000000000\n".
- Backpressure:
  - Stimulus: e stimulus with out_ready toggling 1,0,0,1,…
  - Response: out_char stable during every stall; same 23-character sequence; no duplicates or drops.
- Integer overflow:
  - Stimulus: word0=12, word1=0x4000.
  - Response: "#.25000000000000000000\n"; err=1 until next accepted load.
- Load while busy:
  - Stimulus: second load with different data at the 5th character, and again in the NL cycle.
  - Response: both ignored; the first stream completes unchanged; a load one cycle after busy falls starts a new stream.
- Async reset mid-stream:
  - Stimulus: assert rst during FRAC digit 7, off-edge.
  - Response: out_valid, busy, out_last and err go 0 immediately; after release, IDLE; a new load streams correctly from the integer digit.
